// File: rtl/dds_pkg.sv
// Shared definitions for the DDS/DAC transmit path and the ADC wave meter.
// Holds sample/counter widths, the midscale threshold and hysteresis, the
// measurement FSM state type, DDS word widths, and a saturating increment helper.
package dds_pkg;

    localparam int DATA_W  = 14;
    localparam int MID     = 8192;
    localparam int HYST    = 64;
    localparam int NPER_LG = 4;
    localparam int CNT_W   = 32;
    localparam int TMO_DEF = 32'd16777216;  // 2**24 clk cycles

    localparam int FREQ_W  = 32;            // DDS frequency word width
    localparam int PHASE_W = 12;            // DDS phase/ROM address width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } meas_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/hyst_cross_det.sv
// Hysteretic rising midscale crossing detector.
// Arms (lo_flag) once a sample is at or below MID-HYST and reports a rise on
// the first valid sample at or above MID+HYST afterwards.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clr_i        forces lo_flag low (re-arm from scratch)
//   valid_i      s_q_i carries a fresh sample this cycle
//   s_q_i        registered sample
//   rise_o       combinational lo->hi crossing indication
//   lo_flag_o    current hysteresis state
module hyst_cross_det
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] s_q_i,
    output logic              rise_o,
    output logic              lo_flag_o
);

    // One extra bit so the thresholds can never wrap.
    localparam logic [DATA_W:0] LO_TH = (DATA_W+1)'(MID - HYST);
    localparam logic [DATA_W:0] HI_TH = (DATA_W+1)'(MID + HYST);

    logic [DATA_W:0] s_ext_s;
    logic            lo_flag_q;
    logic            lo_flag_d;

    assign s_ext_s = {1'b0, s_q_i};

    // Hysteresis state update.
    always_comb begin
        lo_flag_d = lo_flag_q;
        if (clr_i) begin
            lo_flag_d = 1'b0;
        end else if (valid_i) begin
            if (s_ext_s <= LO_TH) begin
                lo_flag_d = 1'b1;
            end else if (s_ext_s >= HI_TH) begin
                lo_flag_d = 1'b0;
            end else begin
                lo_flag_d = lo_flag_q;
            end
        end else begin
            lo_flag_d = lo_flag_q;
        end
    end

    // Hysteresis state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_flag_q <= 1'b0;
        end else begin
            lo_flag_q <= lo_flag_d;
        end
    end

    assign rise_o    = valid_i & lo_flag_q & (s_ext_s >= HI_TH);
    assign lo_flag_o = lo_flag_q;

endmodule

// File: rtl/adc_wave_meter.sv
// ADC wave meter: after start, arms on a hysteretic rising midscale crossing,
// times 2**NPER_LG periods in clk cycles and tracks min/max of valid samples.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start          request, honoured only in IDLE
//   s_valid/s_data ADC sample stream (registered once before use)
//   busy           high while arming or measuring
//   done           one-cycle completion pulse (success or timeout)
//   timeout        1 = no valid period measurement
//   period_sum     clk cycles spanning all measured periods
//   period_avg     period_sum >> NPER_LG
//   max_val/min_val/ampl_pp  peak statistics over the measurement window
module adc_wave_meter
    import dds_pkg::*;
#(
    parameter int TMO = TMO_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  period_sum,
    output logic [CNT_W-1:0]  period_avg,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] ampl_pp
);

    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TMO - 1);
    localparam logic [NPER_LG-1:0] PER_LAST = {NPER_LG{1'b1}};

    meas_state_e       state_q, state_d;
    logic [DATA_W-1:0] s_q;
    logic              sv_q;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [NPER_LG-1:0] per_q, per_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  sum_q, sum_d, avg_q, avg_d;
    logic [DATA_W-1:0] max_q, max_d, min_q, min_d, ampl_q, ampl_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic              done_q, done_d, busy_q, busy_d;
    logic              clr_s, rise_s, lo_flag_s;
    logic [DATA_W-1:0] max_nx_s, min_nx_s;
    logic [CNT_W-1:0]  cyc_end_s;

    // Input sample register; holds the last sample between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q  <= {DATA_W{1'b0}};
            sv_q <= 1'b0;
        end else begin
            sv_q <= s_valid;
            if (s_valid) begin
                s_q <= s_data;
            end
        end
    end

    hyst_cross_det u_det (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (clr_s),
        .valid_i   (sv_q),
        .s_q_i     (s_q),
        .rise_o    (rise_s),
        .lo_flag_o (lo_flag_s)
    );

    // Peak candidates including the current valid sample; cycle span ending now.
    assign max_nx_s  = (sv_q && (s_q > max_q)) ? s_q : max_q;
    assign min_nx_s  = (sv_q && (s_q < min_q)) ? s_q : min_q;
    assign cyc_end_s = sat_inc(cyc_q);

    // Next-state, counter and result logic.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        per_d      = per_q;
        tmo_d      = tmo_q;
        sum_d      = sum_q;
        avg_d      = avg_q;
        max_d      = max_q;
        min_d      = min_q;
        ampl_d     = ampl_q;
        tmo_flag_d = tmo_flag_q;
        clr_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARM;
                    cyc_d      = {CNT_W{1'b0}};
                    per_d      = {NPER_LG{1'b0}};
                    tmo_d      = {CNT_W{1'b0}};
                    sum_d      = {CNT_W{1'b0}};
                    avg_d      = {CNT_W{1'b0}};
                    max_d      = {DATA_W{1'b0}};
                    min_d      = {DATA_W{1'b0}};
                    ampl_d     = {DATA_W{1'b0}};
                    tmo_flag_d = 1'b0;
                    clr_s      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                tmo_d = tmo_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (tmo_q == TMO_LAST) begin
                    state_d    = DONE;
                    tmo_flag_d = 1'b1;
                end else if (rise_s) begin
                    state_d = MEAS;
                    cyc_d   = {CNT_W{1'b0}};
                    per_d   = {NPER_LG{1'b0}};
                    max_d   = s_q;
                    min_d   = s_q;
                end else begin
                    state_d = ARM;
                end
            end
            MEAS: begin
                cyc_d = cyc_end_s;
                tmo_d = tmo_q + {{(CNT_W-1){1'b0}}, 1'b1};
                max_d = max_nx_s;
                min_d = min_nx_s;
                // A completing rise beats a coincident timeout.
                if (rise_s && (per_q == PER_LAST)) begin
                    state_d = DONE;
                    sum_d   = cyc_end_s;
                    avg_d   = cyc_end_s >> NPER_LG;
                    ampl_d  = max_nx_s - min_nx_s;
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = DONE;
                    tmo_flag_d = 1'b1;
                    sum_d      = {CNT_W{1'b0}};
                    avg_d      = {CNT_W{1'b0}};
                    ampl_d     = max_nx_s - min_nx_s;
                end else if (rise_s) begin
                    per_d = per_q + {{(NPER_LG-1){1'b0}}, 1'b1};
                end else begin
                    per_d = per_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d == ARM) || (state_d == MEAS);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cyc_q      <= {CNT_W{1'b0}};
            per_q      <= {NPER_LG{1'b0}};
            tmo_q      <= {CNT_W{1'b0}};
            sum_q      <= {CNT_W{1'b0}};
            avg_q      <= {CNT_W{1'b0}};
            max_q      <= {DATA_W{1'b0}};
            min_q      <= {DATA_W{1'b0}};
            ampl_q     <= {DATA_W{1'b0}};
            tmo_flag_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            per_q      <= per_d;
            tmo_q      <= tmo_d;
            sum_q      <= sum_d;
            avg_q      <= avg_d;
            max_q      <= max_d;
            min_q      <= min_d;
            ampl_q     <= ampl_d;
            tmo_flag_q <= tmo_flag_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = tmo_flag_q;
    assign period_sum = sum_q;
    assign period_avg = avg_q;
    assign max_val    = max_q;
    assign min_val    = min_q;
    assign ampl_pp    = ampl_q;

endmodule

// File: tb/tb_adc_wave_meter.sv
// Self-checking bench for adc_wave_meter: square-wave vectors from a table,
// scoreboard of expected results pushed at start and popped on done, plus
// hand sequences for restart-during-measurement and reset mid-measurement.
module tb_adc_wave_meter;
    import dds_pkg::*;

    localparam int TMO_TB = 3000;
    localparam int BUDGET = 8000;

    typedef struct {
        int     p;
        int     v;
        int     hi;
        int     lo;
        longint sum;
        longint avg;
        longint mx;
        longint mn;
        longint pp;
        longint tmo;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              busy, done, timeout;
    logic [CNT_W-1:0]  period_sum, period_avg;
    logic [DATA_W-1:0] max_val, min_val, ampl_pp;

    vec_t sb[$];
    vec_t vt[8];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    adc_wave_meter #(.TMO(TMO_TB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .period_sum (period_sum),
        .period_avg (period_avg),
        .max_val    (max_val),
        .min_val    (min_val),
        .ampl_pp    (ampl_pp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            vec_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("timeout",    longint'(timeout),    e.tmo);
                chk("period_sum", longint'(period_sum), e.sum);
                chk("period_avg", longint'(period_avg), e.avg);
                chk("max_val",    longint'(max_val),    e.mx);
                chk("min_val",    longint'(min_val),    e.mn);
                chk("ampl_pp",    longint'(ampl_pp),    e.pp);
                chk("busy_at_done", longint'(busy),     0);
            end
        end
    end

    // Runs one square-wave measurement. restart_at / reset_at (sample clock
    // index, -1 = never) inject a second start or a mid-run reset.
    task automatic run_case(input vec_t e, input int restart_at, input int reset_at);
        int d0;
        int t;
        int k;
        logic [DATA_W-1:0] smp;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        s_valid = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < BUDGET) begin
            k = t / e.v;
            smp = ((k % e.p) < (e.p / 2)) ? DATA_W'(e.lo) : DATA_W'(e.hi);
            s_valid = ((t % e.v) == 0);
            s_data  = smp;
            start   = (t == restart_at);
            if (t == reset_at) begin
                chk("busy_before_reset", longint'(busy), 1);
                reset = 1'b1;
                #1;
                sb.delete();
                chk("rst_busy", longint'(busy), 0);
                chk("rst_done", longint'(done), 0);
                chk("rst_sum",  longint'(period_sum), 0);
                chk("rst_max",  longint'(max_val), 0);
                chk("rst_state_idle", longint'(dut.state_q), longint'(IDLE));
                repeat (3) @(posedge clk);
                #1;
                reset = 1'b0;
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        if (done_cnt == d0) begin
            chk("done_within_budget", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        int d_before;
        vt[0] = '{100, 1, 16383,    0, 1600, 100, 16383,    0, 16383, 0};
        vt[1] = '{ 25, 4, 12000, 4000, 1600, 100, 12000, 4000,  8000, 0};
        vt[2] = '{ 37, 1,  9000, 7000,  592,  37,  9000, 7000,  2000, 0};
        vt[3] = '{ 20, 1,  8256, 8128,  320,  20,  8256, 8128,   128, 0};
        vt[4] = '{ 10, 3, 14000, 2000,  480,  30, 14000, 2000, 12000, 0};
        vt[5] = '{ 20, 1,  8255, 8128,    0,   0,     0,    0,     0, 1};
        vt[6] = '{ 20, 1,  8256, 8129,    0,   0,     0,    0,     0, 1};
        vt[7] = '{400, 1, 10000, 6000,    0,   0, 10000, 6000,  4000, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",    longint'(busy), 0);
        chk("reset_done",    longint'(done), 0);
        chk("reset_timeout", longint'(timeout), 0);
        chk("reset_sum",     longint'(period_sum), 0);
        chk("reset_avg",     longint'(period_avg), 0);
        chk("reset_max",     longint'(max_val), 0);
        chk("reset_min",     longint'(min_val), 0);
        chk("reset_ampl",    longint'(ampl_pp), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            run_case(vt[i], -1, -1);
            repeat (5) @(posedge clk);
        end

        // Second start mid-measurement is ignored: one done, scenario-1 results.
        d_before = done_cnt;
        run_case(vt[0], 500, -1);
        repeat (20) @(posedge clk);
        #1;
        chk("single_done", longint'(done_cnt - d_before), 1);
        chk("results_hold_sum", longint'(period_sum), 1600);
        chk("results_hold_busy", longint'(busy), 0);

        // Reset after about five periods: no done; a fresh start still works.
        d_before = done_cnt;
        run_case(vt[0], -1, 570);
        repeat (10) @(posedge clk);
        chk("no_done_after_reset", longint'(done_cnt - d_before), 0);
        run_case(vt[0], -1, -1);
        repeat (5) @(posedge clk);
        chk("scoreboard_empty", longint'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
